// File: rtl/sim_console_mux_if.sv
// Tagged byte stream from the console mux to its sink.
interface sim_console_mux_if #(
    parameter int DATA_W = 8,
    parameter int CHAN_W = 1
);
    logic [DATA_W-1:0] out_data;
    logic [CHAN_W-1:0] out_chan;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_chan, output out_valid, input out_ready);
    modport slave  (input out_data, input out_chan, input out_valid, output out_ready);
endinterface

// File: rtl/sim_console_mux.sv
// Console collector: per-channel byte FIFOs drained round-robin into one tagged
// stream, first-exit-code latch with drain-before-done, optional cycle watchdog.
//
// state     | meaning
// S_RUN     | no exit request seen yet
// S_PENDING | exit code latched, waiting for buffered text to drain
// S_DONE    | exit latched and all text drained; held until rst
module sim_console_mux #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int EDGE     = 1,
    parameter int TIMEOUT  = 0,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DATA_W-1:0]   ch_data,
    input  logic [CHANNELS-1:0]          ch_strobe,
    output logic [CHANNELS-1:0]          ch_overflow,
    sim_console_mux_if.master            out_if,
    input  logic                         exit_strobe,
    input  logic [DATA_W-1:0]            exit_code,
    output logic                         done,
    output logic [DATA_W-1:0]            done_code,
    output logic                         timeout
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_PENDING, S_DONE} state_t;
    state_t state, state_nx;

    logic [CHANNELS-1:0]   strobe_q, ev, full, empty, push, pop;
    logic                  exit_q, exit_ev;
    logic [DATA_W-1:0]     mem [CHANNELS][DEPTH];
    logic [PTR_W:0]        wr_ptr [CHANNELS];
    logic [PTR_W:0]        rd_ptr [CHANNELS];
    logic [CHAN_W-1:0]     arb_ptr, gnt_idx, gnt_next;
    logic [CHAN_W:0]       gnt_sum;
    logic                  gnt_found, load;
    logic [2*CHANNELS-1:0] req_rot;
    logic [CNT_W-1:0]      wd_cnt;
    logic                  timeout_q, wd_hit;

    // Previous-sample registers reset high so a strobe held through reset is not an event.
    assign ev      = (EDGE != 0) ? (ch_strobe & ~strobe_q) : ch_strobe;
    assign exit_ev = (EDGE != 0) ? (exit_strobe & ~exit_q) : exit_strobe;
    assign push    = ev & ~full & {CHANNELS{!done}};

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] - rd_ptr[i]) == (PTR_W+1)'(DEPTH));
        end
    end

    assign load    = !out_if.out_valid || out_if.out_ready;
    assign req_rot = {~empty, ~empty} >> arb_ptr;

    // Lowest rotated offset wins, giving the first non-empty FIFO at or above arb_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, arb_ptr} + (CHAN_W+1)'(k);
            end
        end
        if (gnt_sum >= (CHAN_W+1)'(CHANNELS)) gnt_sum = gnt_sum - (CHAN_W+1)'(CHANNELS);
        gnt_idx  = gnt_sum[CHAN_W-1:0];
        gnt_next = (gnt_idx == CHAN_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        pop = '0;
        if (load && gnt_found) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) mem[i][wr_ptr[i][PTR_W-1:0]] <= ch_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q    <= '1;
            exit_q      <= 1'b1;
            ch_overflow <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            strobe_q <= ch_strobe;
            exit_q   <= exit_strobe;
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (ev[i] && full[i] && !done) ch_overflow[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_chan  <= '0;
            arb_ptr          <= '0;
        end else if (load) begin
            out_if.out_valid <= gnt_found;
            if (gnt_found) begin
                out_if.out_data <= mem[gnt_idx][rd_ptr[gnt_idx][PTR_W-1:0]];
                out_if.out_chan <= gnt_idx;
                arb_ptr         <= gnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            done_code <= '0;
        end else begin
            state <= state_nx;
            if (state == S_RUN && exit_ev) done_code <= exit_code;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:     if (exit_ev) state_nx = S_PENDING;
            S_PENDING: if (&empty && !out_if.out_valid) state_nx = S_DONE;
            S_DONE:    state_nx = S_DONE;
            default:   state_nx = S_RUN;
        endcase
    end

    assign done = (state == S_DONE);

    // done already high at the terminal count suppresses the watchdog for good.
    assign wd_hit  = (TIMEOUT > 0) && (wd_cnt == CNT_W'(TIMEOUT)) && !done;
    assign timeout = timeout_q | wd_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((TIMEOUT > 0) && (wd_cnt != CNT_W'(TIMEOUT))) wd_cnt <= wd_cnt + 1'b1;
            timeout_q <= timeout;
        end
    end
endmodule

// File: doc/sim_console_mux.md
Name: sim_console_mux

Overview:
- Multi-channel simulation console and exit-code collector for FPGA and sim tops.
- Accepts byte strobes from CHANNELS GPIO-style output ports and buffers each channel in its own FIFO.
- Drains the FIFOs round-robin into one valid/ready stream tagged with the channel index.
- Latches the first exit code and raises done only after all buffered text has drained. An optional cycle-count watchdog flags timeout.

Parameters:
- CHANNELS, 2, number of console input channels (1..8).
- DATA_W, 8, width of each channel byte and of the exit code.
- DEPTH, 4, per-channel FIFO depth; power of 2, >=2.
- EDGE, 1, 1 = event on 0->1 transition of a strobe; 0 = event on every cycle the strobe is high.
- TIMEOUT, 0, watchdog limit in cycles after reset; 0 disables the watchdog.
- CNT_W, 32, watchdog counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_data  in  CHANNELS*DATA_W  channel i uses bits [i*DATA_W +: DATA_W].
- ch_strobe  in  CHANNELS  per-channel update strobe.
- ch_overflow  out  CHANNELS  sticky; set when a byte is dropped because the FIFO is full.
- out_data  out  DATA_W  byte being presented.
- out_chan  out  max(1,clog2(CHANNELS))  source channel of out_data.
- out_valid  out  1  out_data/out_chan valid.
- out_ready  in  1  sink accepts the byte on a cycle where out_valid&&out_ready.
- exit_strobe  in  1  exit request strobe; EDGE rules apply.
- exit_code  in  DATA_W  code sampled with exit_strobe.
- done  out  1  sticky; exit latched and all text drained.
- done_code  out  DATA_W  latched exit code, valid while done.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; arbiter pointer = 0; watchdog counter = 0.
- Edge-detect previous-sample registers reset to 1, so a strobe held high through reset yields no event.
- Event (EDGE=1): strobe=1 now and 0 on the previous cycle. Event (EDGE=0): strobe=1. Data is sampled in the event cycle.
- Push: on an event, if the channel FIFO is not full, ch_data is written.
- Full is evaluated before any same-cycle pop. An event into a full FIFO is dropped and sets ch_overflow[i], even if a pop occurs that cycle.
- After done, events are ignored and do not set overflow.
- Output register:
  - Loads when empty, or when out_valid&&out_ready (back-to-back throughput 1 byte/cycle).
  - Loads from the first non-empty FIFO searching upward from the arbiter pointer, with wrap-around.
  - On grant to channel g, the pointer becomes (g+1) mod CHANNELS.
  - out_data/out_chan are held stable while out_valid&&!out_ready.
- Latency: an event on cycle t into an empty FIFO with the output register empty gives out_valid=1 at cycle t+1. There is no FIFO-bypass path.
- Ordering: per-channel order is preserved; no byte is duplicated or lost except by overflow.
- Exit:
  - The first exit event latches exit_code into done_code and sets exit_pending; later exit events are ignored.
  - done asserts on the cycle after exit_pending && all FIFOs empty && !out_valid.
  - done stays high until rst.
  - Channel events between exit_pending and done are still accepted and drained.
- Watchdog (TIMEOUT>0):
  - The counter increments every cycle after reset until it reaches TIMEOUT, then holds.
  - timeout asserts the cycle the counter equals TIMEOUT, unless done is already 1.
  - If done and timeout would assert in the same cycle, done wins and timeout stays 0.
  - timeout is sticky and does not block further draining.
- rst mid-operation clears FIFOs, the output register, overflow, exit_pending, done, done_code, timeout and the counter on the next edge. Buffered bytes are discarded.

Test Plan:
- CHANNELS=2, EDGE=1, out_ready=1: ch0 pulses 0x48 then 0x69 (one cycle high, one low each) -> out stream 0x48,0x69 with out_chan=0; out_valid 1 cycle after each event.
- ch0 and ch1 events every cycle for 4 cycles (EDGE=0), out_ready=1 -> output alternates ch0,ch1 starting with ch0; 8 bytes; no overflow.
- out_ready=0, 6 EDGE=0 events on ch1 with DEPTH=4 -> byte 1 in the output register, bytes 2..5 in the FIFO, byte 6 dropped. ch_overflow=2'b10. Then release ready -> exactly 5 bytes in order.
- 3 bytes queued on ch0, out_ready=0, exit_strobe with code 0x05 -> done=0 until 3 bytes consumed; done=1, done_code=0x05 the cycle after the last handshake. A second exit with 0x07 leaves the code at 0x05.
- TIMEOUT=20, no exit -> timeout=1 at cycle 20 after reset and stays set. Exit issued at cycle 10 with empty FIFOs -> done=1, timeout never asserts.
- Strobe held high across rst deassertion (EDGE=1) -> no event. rst asserted with bytes queued -> out_valid=0, overflow=0, done=0 after the edge.
